bid_round_seq: RTL and testbench
================================

BID_ROUND_SEQ -- requirements
Module: bid_round_seq

Interface
REQ-001 Parameter ROUND_TIMEOUT, 1024, max cycles to wait for roundOver after C_start drops.
REQ-002 Parameter OP_TIMEOUT, 64, max cycles to wait for ready before issuing one op.
REQ-003 One clock; reset is asynchronous and active-low. clk  in  1  clock, all state on rising edge.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 cfg_valid  in  1  host offers a round configuration.
REQ-006 cfg_ready  out  1  block accepts configuration (IDLE only).
REQ-007 cfg_key  in  32  key sent with Unlock and Lock.
REQ-008 cfg_xval / cfg_yval / cfg_zval  in  32 each  bidder starting values.
REQ-009 cfg_mask  in  3  XYZ enable mask.
REQ-010 cfg_timer  in  32  round length in cycles.
REQ-011 cfg_cost  in  32  per-bid charge.
REQ-012 C_op  out  4  opcode to auction unit (NoOp=0 … BidCharge=8).
REQ-013 C_data  out  32  operand to auction unit.
REQ-014 C_start  out  1  round-active to auction unit.
REQ-015 ready / err / roundOver  in  1/2/1  auction unit status.
REQ-016 maxBid  in  32; X_win / Y_win / Z_win  in  1 each  round result.
REQ-017 busy  out  1  high in any state except IDLE.
REQ-018 done  out  1  one-cycle pulse, round finished OK.
REQ-019 fail  out  1  one-cycle pulse, round aborted; fail_code  out  2  cause.
REQ-020 res_winner  out  2  0=none/duplicate, 1=X, 2=Y, 3=Z; res_max  out  32  captured maxBid.

Function
REQ-021 Config SHALL be latched on cfg_valid&&cfg_ready; cfg_ready high only in IDLE.
REQ-022 FSM states SHALL be IDLE, WAIT_RDY, ISSUE, CHECK, RUN, CLOSE, WAIT_RES, DONE, FAIL.
REQ-023 Op order fixed: Unlock(key), LoadX(xval), LoadY(yval), LoadZ(zval), SetXYZmask({29'b0,mask}), SetTimer(timer), BidCharge(cost), Lock(key).
REQ-024 WAIT_RDY: wait for ready==1; ISSUE drives C_op/C_data for exactly one cycle; otherwise C_op=NoOp, C_data=0.
REQ-025 CHECK samples err the cycle after ISSUE; err!=0 -> FAIL, fail_code=2'b01; else next op, or RUN after Lock.
REQ-026 OP_TIMEOUT cycles in WAIT_RDY without ready -> FAIL, fail_code=2'b10.
REQ-027 RUN: C_start=1 for max(cfg_timer,1) cycles via 32-bit down-counter, then CLOSE.
REQ-028 CLOSE: C_start=0 one cycle, then WAIT_RES.
REQ-029 WAIT_RES: on roundOver==1 capture maxBid and win flags into res_*, go DONE; ROUND_TIMEOUT cycles elapsed -> FAIL, fail_code=2'b11.
REQ-030 Multiple win flags high SHALL encode res_winner=0 (treated as duplicate).
REQ-031 DONE and FAIL each last one cycle, pulse done/fail, return to IDLE; res_* and fail_code hold until next capture.
REQ-032 cfg_valid while busy SHALL be ignored (no latch, no effect on sequence).
REQ-033 Counters SHALL saturate, never wrap; timeout compare uses >=.

Reset
REQ-034 Async assertion SHALL force IDLE, C_op=NoOp, C_data=0, C_start=0, busy=0, done=0, fail=0, fail_code=0, res_winner=0, res_max=0, cfg_ready=1 after deassert; counters and latched config cleared.
REQ-035 Reset mid-round SHALL drop C_start immediately (asynchronously); no partial op completed afterward.

Structure
REQ-036 Opcode enum, state enum, fail_code and winner encodings SHALL live in package bids22_pkg.
REQ-037 One sub-module natural: bid_cycle_timer (load, decrement, zero flag, saturating timeout), instanced for RUN and for timeouts.

Verification
REQ-038 Config key=0x0F0F0F0F, x/y/z=100/200/300, mask=7, timer=5, cost=1, ready=1, err=0 -> 8 ops in order, C_start high exactly 5 cycles, roundOver+Y_win+maxBid=50 -> done, res_winner=2, res_max=50.
REQ-039 err=2'b10 returned after LoadY -> no further ops, fail pulse, fail_code=01, C_start never asserted.
REQ-040 ready held 0 for 64 cycles -> fail, fail_code=10.
REQ-041 roundOver never asserted -> fail at 1024 cycles after CLOSE, fail_code=11; timer=0 -> C_start high 1 cycle.
REQ-042 reset_n low during RUN -> C_start 0 same cycle, all outputs at reset values; new config after release runs full sequence.
REQ-043 X_win and Z_win both high at roundOver -> res_winner=0, done pulse; cfg_valid during RUN ignored.

Source files
------------

// File: rtl/bids22_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bids22_pkg
// Description : Shared encodings for the bid round sequencer: auction-unit
//               opcodes, sequencer states, fail causes and winner codes,
//               plus helpers for the fixed op order and winner encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package bids22_pkg;

  typedef enum logic [3:0] {
    OP_NOOP       = 4'd0,
    OP_UNLOCK     = 4'd1,
    OP_LOCK       = 4'd2,
    OP_LOAD_X     = 4'd3,
    OP_LOAD_Y     = 4'd4,
    OP_LOAD_Z     = 4'd5,
    OP_SET_MASK   = 4'd6,
    OP_SET_TIMER  = 4'd7,
    OP_BID_CHARGE = 4'd8
  } op_e;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_WAIT_RDY = 4'd1,
    ST_ISSUE    = 4'd2,
    ST_CHECK    = 4'd3,
    ST_RUN      = 4'd4,
    ST_CLOSE    = 4'd5,
    ST_WAIT_RES = 4'd6,
    ST_DONE     = 4'd7,
    ST_FAIL     = 4'd8
  } state_e;

  localparam logic [1:0] c_fail_none          = 2'b00;
  localparam logic [1:0] c_fail_err           = 2'b01;
  localparam logic [1:0] c_fail_op_timeout    = 2'b10;
  localparam logic [1:0] c_fail_round_timeout = 2'b11;

  localparam logic [1:0] c_win_none = 2'd0;
  localparam logic [1:0] c_win_x    = 2'd1;
  localparam logic [1:0] c_win_y    = 2'd2;
  localparam logic [1:0] c_win_z    = 2'd3;

  localparam logic [2:0] c_last_op_idx = 3'd7;

  // Fixed configuration order: Unlock, X, Y, Z, mask, timer, cost, Lock.
  function automatic op_e op_at(input logic [2:0] idx);
    op_e op;
    case (idx)
      3'd0:    op = OP_UNLOCK;
      3'd1:    op = OP_LOAD_X;
      3'd2:    op = OP_LOAD_Y;
      3'd3:    op = OP_LOAD_Z;
      3'd4:    op = OP_SET_MASK;
      3'd5:    op = OP_SET_TIMER;
      3'd6:    op = OP_BID_CHARGE;
      default: op = OP_LOCK;
    endcase
    return op;
  endfunction

  // More than one winner flag is reported as "no winner" (duplicate).
  function automatic logic [1:0] encode_winner(input logic x, input logic y, input logic z);
    logic [1:0] code;
    case ({x, y, z})
      3'b100:  code = c_win_x;
      3'b010:  code = c_win_y;
      3'b001:  code = c_win_z;
      default: code = c_win_none;
    endcase
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bid_cycle_timer.sv
`default_nettype none
// ============================================================================
// Module      : bid_cycle_timer
// Description : 32-bit cycle counter. load has priority and sets the count
//               to load_val; en steps it one cycle. Counting down it stops
//               at zero, counting up it stops at all-ones, so it never wraps.
//               flag: down -> count == LIMIT, up -> count >= LIMIT.
// Ports       : clk, reset_n (async active-low), load, load_val[31:0], en,
//               flag
// Revision    : 1.0 - initial release
// ============================================================================
module bid_cycle_timer #(
  parameter bit          COUNT_UP = 1'b0,
  parameter int unsigned LIMIT    = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        en,
  output logic        flag
);

  logic [31:0] r_count;

  generate
    if (COUNT_UP) begin : g_up
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                          r_count <= 32'd0;
        else if (load)                         r_count <= load_val;
        else if (en && (r_count != 32'hFFFF_FFFF)) r_count <= r_count + 32'd1;
      end
      assign flag = (r_count >= 32'(LIMIT));
    end else begin : g_down
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                     r_count <= 32'd0;
        else if (load)                    r_count <= load_val;
        else if (en && (r_count != 32'd0)) r_count <= r_count - 32'd1;
      end
      assign flag = (r_count == 32'(LIMIT));
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/bid_round_seq.sv
`default_nettype none
// ============================================================================
// Module      : bid_round_seq
// Description : Runs one auction round: latches a configuration, issues the
//               eight configuration ops to the auction unit (each gated on
//               ready and checked for err), holds C_start for the round
//               length, then waits for roundOver and captures the result.
// Ports       : clk, reset_n (async active-low)
//               cfg_valid/cfg_ready, cfg_key/xval/yval/zval/mask/timer/cost
//               C_op[3:0], C_data[31:0], C_start      -> auction unit
//               ready, err[1:0], roundOver, maxBid, X/Y/Z_win <- auction unit
//               busy, done, fail, fail_code[1:0], res_winner[1:0], res_max
// Revision    : 1.0 - initial release
// ============================================================================
module bid_round_seq
  import bids22_pkg::*;
#(
  parameter int unsigned ROUND_TIMEOUT = 1024,
  parameter int unsigned OP_TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [31:0] cfg_key,
  input  logic [31:0] cfg_xval,
  input  logic [31:0] cfg_yval,
  input  logic [31:0] cfg_zval,
  input  logic [2:0]  cfg_mask,
  input  logic [31:0] cfg_timer,
  input  logic [31:0] cfg_cost,
  output logic [3:0]  C_op,
  output logic [31:0] C_data,
  output logic        C_start,
  input  logic        ready,
  input  logic [1:0]  err,
  input  logic        roundOver,
  input  logic [31:0] maxBid,
  input  logic        X_win,
  input  logic        Y_win,
  input  logic        Z_win,
  output logic        busy,
  output logic        done,
  output logic        fail,
  output logic [1:0]  fail_code,
  output logic [1:0]  res_winner,
  output logic [31:0] res_max
);

  state_e      r_state;
  logic [2:0]  r_op_idx;
  op_e         r_c_op;
  logic [31:0] r_c_data;
  logic        r_c_start;
  logic        r_done;
  logic        r_fail;
  logic [1:0]  r_fail_code;
  logic [1:0]  r_res_winner;
  logic [31:0] r_res_max;

  logic [31:0] r_cfg_key, r_cfg_xval, r_cfg_yval, r_cfg_zval;
  logic [31:0] r_cfg_timer, r_cfg_cost;
  logic [2:0]  r_cfg_mask;

  logic [31:0] w_op_data;
  logic [31:0] w_run_load_val;
  logic        w_run_zero;
  logic        w_op_expired;
  logic        w_round_expired;

  always_comb begin
    w_op_data = 32'd0;
    case (r_op_idx)
      3'd0:    w_op_data = r_cfg_key;
      3'd1:    w_op_data = r_cfg_xval;
      3'd2:    w_op_data = r_cfg_yval;
      3'd3:    w_op_data = r_cfg_zval;
      3'd4:    w_op_data = {29'b0, r_cfg_mask};
      3'd5:    w_op_data = r_cfg_timer;
      3'd6:    w_op_data = r_cfg_cost;
      default: w_op_data = r_cfg_key;
    endcase
  end

  // Round length is max(timer,1); the down-counter is loaded with length-1
  // so RUN exits on the cycle the counter sits at zero.
  assign w_run_load_val = (r_cfg_timer == 32'd0) ? 32'd0 : (r_cfg_timer - 32'd1);

  // Each timer is held loaded outside its owning state, so it restarts
  // from its initial value every time that state is entered.
  bid_cycle_timer #(.COUNT_UP(1'b0), .LIMIT(0)) u_run_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (r_state != ST_RUN),
    .load_val (w_run_load_val),
    .en       (r_state == ST_RUN),
    .flag     (w_run_zero)
  );

  bid_cycle_timer #(.COUNT_UP(1'b1), .LIMIT(OP_TIMEOUT)) u_op_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (r_state != ST_WAIT_RDY),
    .load_val (32'd0),
    .en       (r_state == ST_WAIT_RDY),
    .flag     (w_op_expired)
  );

  bid_cycle_timer #(.COUNT_UP(1'b1), .LIMIT(ROUND_TIMEOUT)) u_round_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (r_state != ST_WAIT_RES),
    .load_val (32'd0),
    .en       (r_state == ST_WAIT_RES),
    .flag     (w_round_expired)
  );

  // C_start is a plain async-reset flop, so reset drops it without a clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_op_idx     <= 3'd0;
      r_c_op       <= OP_NOOP;
      r_c_data     <= 32'd0;
      r_c_start    <= 1'b0;
      r_done       <= 1'b0;
      r_fail       <= 1'b0;
      r_fail_code  <= c_fail_none;
      r_res_winner <= c_win_none;
      r_res_max    <= 32'd0;
      r_cfg_key    <= 32'd0;
      r_cfg_xval   <= 32'd0;
      r_cfg_yval   <= 32'd0;
      r_cfg_zval   <= 32'd0;
      r_cfg_mask   <= 3'd0;
      r_cfg_timer  <= 32'd0;
      r_cfg_cost   <= 32'd0;
    end else begin
      r_done <= 1'b0;
      r_fail <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cfg_valid) begin
            r_cfg_key   <= cfg_key;
            r_cfg_xval  <= cfg_xval;
            r_cfg_yval  <= cfg_yval;
            r_cfg_zval  <= cfg_zval;
            r_cfg_mask  <= cfg_mask;
            r_cfg_timer <= cfg_timer;
            r_cfg_cost  <= cfg_cost;
            r_op_idx    <= 3'd0;
            r_state     <= ST_WAIT_RDY;
          end
        end
        ST_WAIT_RDY: begin
          if (ready) begin
            r_c_op   <= op_at(r_op_idx);
            r_c_data <= w_op_data;
            r_state  <= ST_ISSUE;
          end else if (w_op_expired) begin
            r_fail      <= 1'b1;
            r_fail_code <= c_fail_op_timeout;
            r_state     <= ST_FAIL;
          end
        end
        ST_ISSUE: begin
          r_c_op   <= OP_NOOP;
          r_c_data <= 32'd0;
          r_state  <= ST_CHECK;
        end
        ST_CHECK: begin
          if (err != 2'b00) begin
            r_fail      <= 1'b1;
            r_fail_code <= c_fail_err;
            r_state     <= ST_FAIL;
          end else if (r_op_idx == c_last_op_idx) begin
            r_c_start <= 1'b1;
            r_state   <= ST_RUN;
          end else begin
            r_op_idx <= r_op_idx + 3'd1;
            r_state  <= ST_WAIT_RDY;
          end
        end
        ST_RUN: begin
          if (w_run_zero) begin
            r_c_start <= 1'b0;
            r_state   <= ST_CLOSE;
          end
        end
        ST_CLOSE: r_state <= ST_WAIT_RES;
        ST_WAIT_RES: begin
          if (roundOver) begin
            r_res_max    <= maxBid;
            r_res_winner <= encode_winner(X_win, Y_win, Z_win);
            r_done       <= 1'b1;
            r_state      <= ST_DONE;
          end else if (w_round_expired) begin
            r_fail      <= 1'b1;
            r_fail_code <= c_fail_round_timeout;
            r_state     <= ST_FAIL;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        ST_FAIL: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cfg_ready  = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign C_op       = r_c_op;
  assign C_data     = r_c_data;
  assign C_start    = r_c_start;
  assign done       = r_done;
  assign fail       = r_fail;
  assign fail_code  = r_fail_code;
  assign res_winner = r_res_winner;
  assign res_max    = r_res_max;

endmodule
`default_nettype wire

// File: tb/tb_bid_round_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bid_round_seq
// Description : Directed self-checking bench for bid_round_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bid_round_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_key, cfg_xval, cfg_yval, cfg_zval, cfg_timer, cfg_cost;
  logic [2:0]  cfg_mask;
  logic [3:0]  C_op;
  logic [31:0] C_data;
  logic        C_start;
  logic        ready;
  logic [1:0]  err;
  logic        roundOver;
  logic [31:0] maxBid;
  logic        X_win, Y_win, Z_win;
  logic        busy, done, fail;
  logic [1:0]  fail_code, res_winner;
  logic [31:0] res_max;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bid_round_seq #(.ROUND_TIMEOUT(1024), .OP_TIMEOUT(64)) dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_key(cfg_key), .cfg_xval(cfg_xval), .cfg_yval(cfg_yval), .cfg_zval(cfg_zval),
    .cfg_mask(cfg_mask), .cfg_timer(cfg_timer), .cfg_cost(cfg_cost),
    .C_op(C_op), .C_data(C_data), .C_start(C_start),
    .ready(ready), .err(err), .roundOver(roundOver), .maxBid(maxBid),
    .X_win(X_win), .Y_win(Y_win), .Z_win(Z_win),
    .busy(busy), .done(done), .fail(fail), .fail_code(fail_code),
    .res_winner(res_winner), .res_max(res_max)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while idle; the next rising edge accepts.
  task automatic apply_cfg(input logic [31:0] key, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] z, input logic [2:0] mask,
                           input logic [31:0] timer, input logic [31:0] cost);
    cfg_key = key; cfg_xval = x; cfg_yval = y; cfg_zval = z;
    cfg_mask = mask; cfg_timer = timer; cfg_cost = cost;
    cfg_valid = 1'b1;
    @(negedge clk);
    chk("accept_busy", {31'b0, busy}, 32'd1);
    chk("accept_cfg_ready_low", {31'b0, cfg_ready}, 32'd0);
    cfg_valid = 1'b0;
  endtask

  // Waits for the next issued op, checks it, drives err for its CHECK cycle,
  // and returns at the CHECK-cycle negedge.
  task automatic expect_op(input logic [3:0] op, input logic [31:0] data, input logic [1:0] err_val);
    int n = 0;
    while (C_op === 4'd0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("op_code", {28'b0, C_op}, {28'b0, op});
    chk("op_data", C_data, data);
    err = err_val;
    @(negedge clk);
    chk("op_one_cycle", {28'b0, C_op}, 32'd0);
  endtask

  task automatic run_ops(input logic [31:0] key, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] z, input logic [2:0] mask,
                         input logic [31:0] timer, input logic [31:0] cost);
    logic [3:0]  ops [8];
    logic [31:0] dat [8];
    ops = '{4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd2};
    dat = '{key, x, y, z, {29'b0, mask}, timer, cost, key};
    for (int i = 0; i < 8; i++) expect_op(ops[i], dat[i], 2'b00);
  endtask

  // Counts C_start-high cycles; returns at the first negedge with it low.
  task automatic measure_start(output int n);
    int w = 0;
    n = 0;
    while (C_start !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    while (C_start === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_end(output int cycles);
    cycles = 0;
    while (!(done === 1'b1 || fail === 1'b1) && cycles < 2000) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int c;
    int bad;

    reset_n = 1'b0; cfg_valid = 1'b0;
    cfg_key = '0; cfg_xval = '0; cfg_yval = '0; cfg_zval = '0;
    cfg_mask = '0; cfg_timer = '0; cfg_cost = '0;
    ready = 1'b0; err = 2'b00; roundOver = 1'b0; maxBid = '0;
    X_win = 1'b0; Y_win = 1'b0; Z_win = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_C_op", {28'b0, C_op}, 32'd0);
    chk("rst_C_data", C_data, 32'd0);
    chk("rst_C_start", {31'b0, C_start}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_fail", {31'b0, fail}, 32'd0);
    chk("rst_fail_code", {30'b0, fail_code}, 32'd0);
    chk("rst_res_winner", {30'b0, res_winner}, 32'd0);
    chk("rst_res_max", res_max, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_cfg_ready", {31'b0, cfg_ready}, 32'd1);

    // Nominal round, Y wins with 50.
    ready = 1'b1;
    apply_cfg(32'h0F0F_0F0F, 32'd100, 32'd200, 32'd300, 3'd7, 32'd5, 32'd1);
    run_ops(32'h0F0F_0F0F, 32'd100, 32'd200, 32'd300, 3'd7, 32'd5, 32'd1);
    measure_start(n);
    chk("t1_run_len", n, 32'd5);
    roundOver = 1'b1; Y_win = 1'b1; maxBid = 32'd50;
    wait_end(c);
    chk("t1_end_latency", c, 32'd2);
    chk("t1_done", {31'b0, done}, 32'd1);
    chk("t1_fail", {31'b0, fail}, 32'd0);
    chk("t1_res_winner", {30'b0, res_winner}, 32'd2);
    chk("t1_res_max", res_max, 32'd50);
    roundOver = 1'b0; Y_win = 1'b0; maxBid = 32'd0;
    @(negedge clk);
    chk("t1_done_pulse", {31'b0, done}, 32'd0);
    chk("t1_idle", {31'b0, busy}, 32'd0);

    // err returned after LoadY aborts the sequence.
    apply_cfg(32'hA5A5_0001, 32'd1, 32'd2, 32'd3, 3'd5, 32'd7, 32'd2);
    expect_op(4'd1, 32'hA5A5_0001, 2'b00);
    expect_op(4'd3, 32'd1, 2'b00);
    expect_op(4'd4, 32'd2, 2'b10);
    @(negedge clk);
    err = 2'b00;
    chk("t2_fail", {31'b0, fail}, 32'd1);
    chk("t2_fail_code", {30'b0, fail_code}, 32'd1);
    chk("t2_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    chk("t2_fail_pulse", {31'b0, fail}, 32'd0);
    chk("t2_fail_code_hold", {30'b0, fail_code}, 32'd1);
    chk("t2_idle", {31'b0, busy}, 32'd0);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (C_op !== 4'd0 || C_start !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("t2_no_activity", bad, 32'd0);

    // ready never arrives.
    ready = 1'b0;
    apply_cfg(32'h1111_2222, 32'd4, 32'd5, 32'd6, 3'd1, 32'd9, 32'd1);
    wait_end(c);
    chk("t3_fail", {31'b0, fail}, 32'd1);
    chk("t3_fail_code", {30'b0, fail_code}, 32'd2);
    chk("t3_latency", c, 32'd65);
    @(negedge clk);
    chk("t3_idle", {31'b0, busy}, 32'd0);
    ready = 1'b1;

    // timer=0 gives a one-cycle round; roundOver never comes.
    apply_cfg(32'h3333_4444, 32'd10, 32'd20, 32'd30, 3'd3, 32'd0, 32'd9);
    run_ops(32'h3333_4444, 32'd10, 32'd20, 32'd30, 3'd3, 32'd0, 32'd9);
    measure_start(n);
    chk("t4_run_len", n, 32'd1);
    wait_end(c);
    chk("t4_latency", c, 32'd1026);
    chk("t4_fail", {31'b0, fail}, 32'd1);
    chk("t4_fail_code", {30'b0, fail_code}, 32'd3);
    chk("t4_res_winner_hold", {30'b0, res_winner}, 32'd2);
    chk("t4_res_max_hold", res_max, 32'd50);
    @(negedge clk);

    // Reset in the middle of RUN.
    apply_cfg(32'h5555_6666, 32'd11, 32'd22, 32'd33, 3'd1, 32'd20, 32'd4);
    run_ops(32'h5555_6666, 32'd11, 32'd22, 32'd33, 3'd1, 32'd20, 32'd4);
    c = 0;
    while (C_start !== 1'b1 && c < 40) begin
      @(negedge clk);
      c++;
    end
    chk("t5_in_run", {31'b0, C_start}, 32'd1);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_async_C_start", {31'b0, C_start}, 32'd0);
    chk("t5_rst_busy", {31'b0, busy}, 32'd0);
    chk("t5_rst_cfg_ready", {31'b0, cfg_ready}, 32'd1);
    chk("t5_rst_C_op", {28'b0, C_op}, 32'd0);
    chk("t5_rst_C_data", C_data, 32'd0);
    chk("t5_rst_fail_code", {30'b0, fail_code}, 32'd0);
    chk("t5_rst_res_winner", {30'b0, res_winner}, 32'd0);
    chk("t5_rst_res_max", res_max, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    apply_cfg(32'h1234_5678, 32'd7, 32'd8, 32'd9, 3'd4, 32'd3, 32'd2);
    run_ops(32'h1234_5678, 32'd7, 32'd8, 32'd9, 3'd4, 32'd3, 32'd2);
    measure_start(n);
    chk("t5_run_len", n, 32'd3);
    roundOver = 1'b1; X_win = 1'b1; maxBid = 32'd77;
    wait_end(c);
    chk("t5_done", {31'b0, done}, 32'd1);
    chk("t5_res_winner", {30'b0, res_winner}, 32'd1);
    chk("t5_res_max", res_max, 32'd77);
    roundOver = 1'b0; X_win = 1'b0; maxBid = 32'd0;
    @(negedge clk);

    // Duplicate winners; a second configuration offered while busy is ignored.
    apply_cfg(32'hCAFE_F00D, 32'd5, 32'd6, 32'd7, 3'd6, 32'd4, 32'd3);
    cfg_valid = 1'b1;
    cfg_key = 32'hDEAD_BEEF; cfg_xval = 32'd999; cfg_yval = 32'd998; cfg_zval = 32'd997;
    cfg_mask = 3'd1; cfg_timer = 32'd100; cfg_cost = 32'd50;
    run_ops(32'hCAFE_F00D, 32'd5, 32'd6, 32'd7, 3'd6, 32'd4, 32'd3);
    measure_start(n);
    chk("t6_run_len", n, 32'd4);
    roundOver = 1'b1; X_win = 1'b1; Z_win = 1'b1; maxBid = 32'd123;
    wait_end(c);
    chk("t6_done", {31'b0, done}, 32'd1);
    chk("t6_res_winner_dup", {30'b0, res_winner}, 32'd0);
    chk("t6_res_max", res_max, 32'd123);
    cfg_valid = 1'b0;
    roundOver = 1'b0; X_win = 1'b0; Z_win = 1'b0; maxBid = 32'd0;
    repeat (2) @(negedge clk);
    chk("t6_idle", {31'b0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
